pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
- Program-counter and fetch sequencer that sits directly upstream of the control unit.
- Holds the PC that addresses instruction memory; the fetched word's opcode field feeds the control unit.
- Consumes the control unit's jmp/beq/bne/hlt/flagIN outputs and the ALU zero flag, and produces the `checkin` handshake the control unit uses to resolve IN instructions.
- Owns the run/wait-for-input/halted state machine.

Parameters:
- ADDR_W, 10, PC / instruction-address width in bits.
- DATA_W, 32, width of the user input word latched for IN.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- jmp  input  1  jump request from control unit.
- jmp_sel  input  2  AluSelec from control unit: 01 = absolute jump to imm_addr, 11 = jump to reg_addr.
- beq  input  1  branch-if-equal from control unit.
- bne  input  1  branch-if-not-equal from control unit.
- zero  input  1  ALU zero flag for the current instruction.
- hlt  input  1  halt request from control unit.
- flag_in  input  1  flagIN from control unit (current instruction is IN).
- imm_addr  input  ADDR_W  immediate target from instruction word.
- reg_addr  input  ADDR_W  register-sourced target (jmpr).
- in_btn  input  1  asynchronous user "enter" button, active-high.
- in_data  input  DATA_W  user switch value.
- pc  output  ADDR_W  current instruction address.
- checkin  output  1  input-available handshake to control unit.
- in_value  output  DATA_W  latched input word for register write-back.
- state  output  2  00 RUN, 01 WAIT_IN, 10 HALTED (debug/LEDs).

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=RUN, checkin=0, in_value=0, button edge-detect regs=0. rst dominates every other input, including mid-WAIT_IN and HALTED.
- RUN, one instruction per cycle. Next-PC priority, highest first:
  1. hlt&flag_in: pc held, go to WAIT_IN.
  2. hlt&!flag_in: pc held, go to HALTED.
  3. jmp with jmp_sel=11: pc=reg_addr.
  4. jmp with any other jmp_sel: pc=imm_addr.
  5. (beq&zero)|(bne&!zero): pc=imm_addr.
  6. Otherwise pc=pc+1, wrapping modulo 2^ADDR_W (all-ones wraps to 0).
- beq and bne both high is illegal; treat it as the OR of the two conditions.
- WAIT_IN:
  - pc held.
  - On a detected rising edge of the synchronized in_btn: in_value=in_data (sampled that cycle), checkin=1, go to RUN.
  - Button held high on entry does not count; a fresh 0→1 transition is required.
- checkin lifecycle:
  - Registered.
  - Stays 1 until the first RUN cycle in which flag_in=1 and hlt=0, i.e. the control unit has accepted the IN. In that cycle pc advances normally and checkin clears at the same edge.
  - Net latency from button edge to pc advance is 2 cycles after synchronization.
- HALTED: pc, in_value and checkin frozen; only rst exits.
- Edge detector: the previous-sample register updates every cycle in every state, so presses in RUN are ignored, not queued.
- The block has no outputs that depend combinationally on inputs; pc, checkin, in_value and state are all registers.

Optional Feature:
- IN_SYNC_EN defined: in_btn passes through a 2-flop synchronizer before the edge detector. Edge-to-checkin latency is 3 cycles from the asynchronous transition.
- IN_SYNC_EN undefined: in_btn feeds the edge detector directly, with 1 cycle latency. Use only when in_btn is already synchronous to clk (simulation or debounced upstream).

Test Plan:
- Reset then 5 cycles of no control strobes → pc steps 0,1,2,3,4,5. Then pc=1023 with ADDR_W=10 → next pc=0.
- pc=7, jmp=1, jmp_sel=01, imm_addr=40 → pc=40. Then jmp_sel=11, reg_addr=300 → pc=300.
- beq=1, zero=1, imm_addr=12 → pc=12. Then beq=1, zero=0 → pc=13. Then bne=1, zero=0, imm_addr=2 → pc=2.
- IN at pc=20: hlt=1, flag_in=1 → state=01, pc stays 20. Hold in_btn=1 from entry → no exit. Release, press with in_data=0xA5 → in_value=0xA5, checkin=1, state=00. Next cycle with hlt=0, flag_in=1 → pc=21, checkin=0.
- hlt=1, flag_in=0 at pc=9 → state=10, pc=9 for 50 cycles despite jmp/in_btn activity. rst=1 → pc=0, state=00.
- rst asserted in WAIT_IN in the same cycle as a button edge → pc=0, checkin=0, in_value=0, state=00.

Source files
------------

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-sequencer bus: control-unit strobes and user input in, PC/handshake/input word out.
interface pc_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              jmp;
  logic [1:0]        jmp_sel;
  logic              beq;
  logic              bne;
  logic              zero;
  logic              hlt;
  logic              flag_in;
  logic [ADDR_W-1:0] imm_addr;
  logic [ADDR_W-1:0] reg_addr;
  logic              in_btn;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] pc;
  logic              checkin;
  logic [DATA_W-1:0] in_value;
  logic [1:0]        state;

  modport master (
    output jmp, jmp_sel, beq, bne, zero, hlt, flag_in, imm_addr, reg_addr, in_btn, in_data,
    input  pc, checkin, in_value, state
  );

  modport slave (
    input  jmp, jmp_sel, beq, bne, zero, hlt, flag_in, imm_addr, reg_addr, in_btn, in_data,
    output pc, checkin, in_value, state
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// PC / fetch sequencer with RUN, WAIT_IN and HALTED states and IN-instruction handshake.
// Define IN_SYNC_EN to put a 2-flop synchronizer in front of the in_btn edge detector.
module pc_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 10,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                  clk,
  input logic                  rst,
  pc_fetch_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    WAIT_IN = 2'b01,
    HALTED  = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              checkin_q, checkin_d;
  logic [DATA_W-1:0] in_value_q, in_value_d;
  logic              btn_sync, btn_prev, btn_rise;

`ifdef IN_SYNC_EN
  logic btn_s1, btn_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= bus.in_btn;
      btn_s2 <= btn_s1;
    end
  end

  assign btn_sync = btn_s2;
`else
  assign btn_sync = bus.in_btn;
`endif

  // Previous sample tracks every cycle, so a held button or a press made in RUN never fires later.
  always_ff @(posedge clk) begin
    if (rst) btn_prev <= 1'b0;
    else     btn_prev <= btn_sync;
  end

  assign btn_rise = btn_sync & ~btn_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      checkin_q  <= 1'b0;
      in_value_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      checkin_q  <= checkin_d;
      in_value_q <= in_value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bus.hlt && bus.flag_in) state_d = WAIT_IN;
        else if (bus.hlt)           state_d = HALTED;
      end
      WAIT_IN: if (btn_rise) state_d = RUN;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    checkin_d  = checkin_q;
    in_value_d = in_value_q;
    unique case (state_q)
      RUN: begin
        if (!bus.hlt) begin
          if (bus.jmp)
            pc_d = (bus.jmp_sel == 2'b11) ? bus.reg_addr : bus.imm_addr;
          else if ((bus.beq && bus.zero) || (bus.bne && !bus.zero))
            pc_d = bus.imm_addr;
          else
            pc_d = pc_q + 1'b1;
          // Control unit consumes the IN word on its first non-halting IN cycle.
          if (bus.flag_in) checkin_d = 1'b0;
        end
      end
      WAIT_IN: begin
        if (btn_rise) begin
          in_value_d = bus.in_data;
          checkin_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.checkin  = checkin_q;
  assign bus.in_value = in_value_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed-vector bench for pc_fetch_sequencer with hand-computed expectations.
module tb_pc_fetch_sequencer;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned vectors = 0;
  int unsigned errors  = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pc_fetch_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(10'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.jmp      = 1'b0;
    bus.jmp_sel  = 2'b00;
    bus.beq      = 1'b0;
    bus.bne      = 1'b0;
    bus.zero     = 1'b0;
    bus.hlt      = 1'b0;
    bus.flag_in  = 1'b0;
  endtask

  task automatic jump_to(input logic [ADDR_W-1:0] a);
    idle();
    bus.jmp      = 1'b1;
    bus.jmp_sel  = 2'b01;
    bus.imm_addr = a;
    step();
    idle();
  endtask

  initial begin
    idle();
    bus.imm_addr = '0;
    bus.reg_addr = '0;
    bus.in_btn   = 1'b0;
    bus.in_data  = '0;

    // Reset
    rst = 1'b1;
    step();
    step();
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_checkin", 32'(bus.checkin), 32'd0);
    chk("rst_in_value", bus.in_value, 32'd0);
    rst = 1'b0;

    // Sequential fetch
    for (int unsigned i = 1; i <= 5; i++) begin
      step();
      chk("seq_pc", 32'(bus.pc), i);
    end

    // Wrap
    jump_to(10'd1023);
    chk("jmp_1023", 32'(bus.pc), 32'd1023);
    step();
    chk("wrap_pc", 32'(bus.pc), 32'd0);

    // Jumps
    jump_to(10'd7);
    chk("pc7", 32'(bus.pc), 32'd7);
    bus.jmp = 1'b1; bus.jmp_sel = 2'b01; bus.imm_addr = 10'd40; bus.reg_addr = 10'd300;
    step();
    chk("jmp_imm", 32'(bus.pc), 32'd40);
    bus.jmp_sel = 2'b11;
    step();
    chk("jmp_reg", 32'(bus.pc), 32'd300);
    bus.jmp_sel = 2'b10; bus.imm_addr = 10'd55;
    step();
    chk("jmp_sel10", 32'(bus.pc), 32'd55);
    bus.jmp_sel = 2'b11; bus.hlt = 1'b0; bus.beq = 1'b1; bus.zero = 1'b1; bus.imm_addr = 10'd77;
    step();
    chk("jmp_over_beq", 32'(bus.pc), 32'd300);
    idle();

    // Branches
    bus.beq = 1'b1; bus.zero = 1'b1; bus.imm_addr = 10'd12;
    step();
    chk("beq_taken", 32'(bus.pc), 32'd12);
    bus.zero = 1'b0;
    step();
    chk("beq_not", 32'(bus.pc), 32'd13);
    idle();
    bus.bne = 1'b1; bus.zero = 1'b0; bus.imm_addr = 10'd2;
    step();
    chk("bne_taken", 32'(bus.pc), 32'd2);
    bus.zero = 1'b1;
    step();
    chk("bne_not", 32'(bus.pc), 32'd3);
    bus.beq = 1'b1; bus.bne = 1'b1; bus.zero = 1'b0; bus.imm_addr = 10'd99;
    step();
    chk("beq_bne_or", 32'(bus.pc), 32'd99);
    idle();

    // IN with button held on entry
    jump_to(10'd20);
    bus.hlt = 1'b1; bus.flag_in = 1'b1; bus.in_btn = 1'b1;
    step();
    chk("win_state", 32'(bus.state), 32'd1);
    chk("win_pc", 32'(bus.pc), 32'd20);
    idle();
    bus.jmp = 1'b1; bus.imm_addr = 10'd500;
    for (int unsigned i = 0; i < 4; i++) step();
    chk("held_state", 32'(bus.state), 32'd1);
    chk("held_pc", 32'(bus.pc), 32'd20);
    chk("held_checkin", 32'(bus.checkin), 32'd0);
    idle();
    bus.in_btn = 1'b0;
    step();
    step();
    bus.in_btn = 1'b1; bus.in_data = 32'hA5;
    for (int unsigned i = 0; i < 6 && bus.state != 2'b00; i++) step();
    chk("press_state", 32'(bus.state), 32'd0);
    chk("press_value", bus.in_value, 32'hA5);
    chk("press_checkin", 32'(bus.checkin), 32'd1);
    chk("press_pc", 32'(bus.pc), 32'd20);
    bus.in_btn = 1'b0; bus.in_data = 32'h0;
    bus.flag_in = 1'b1;
    step();
    chk("accept_pc", 32'(bus.pc), 32'd21);
    chk("accept_checkin", 32'(bus.checkin), 32'd0);
    chk("accept_value", bus.in_value, 32'hA5);
    idle();

    // Press in RUN is not queued
    bus.in_btn = 1'b1;
    step();
    chk("run_press_pc", 32'(bus.pc), 32'd22);
    bus.in_btn = 1'b0;
    step();
    bus.hlt = 1'b1; bus.flag_in = 1'b1;
    step();
    idle();
    for (int unsigned i = 0; i < 4; i++) step();
    chk("noqueue_state", 32'(bus.state), 32'd1);
    chk("noqueue_pc", 32'(bus.pc), 32'd23);

    // Reset coincident with button edge in WAIT_IN
    rst = 1'b1; bus.in_btn = 1'b1; bus.in_data = 32'h5A;
    step();
    rst = 1'b0;
    chk("rstwin_pc", 32'(bus.pc), 32'd0);
    chk("rstwin_checkin", 32'(bus.checkin), 32'd0);
    chk("rstwin_value", bus.in_value, 32'd0);
    chk("rstwin_state", 32'(bus.state), 32'd0);
    bus.in_btn = 1'b0;

    // Halt
    jump_to(10'd9);
    chk("pc9", 32'(bus.pc), 32'd9);
    bus.hlt = 1'b1; bus.flag_in = 1'b0;
    step();
    chk("halt_state", 32'(bus.state), 32'd2);
    for (int unsigned i = 0; i < 50; i++) begin
      bus.jmp      = i[0];
      bus.jmp_sel  = i[2:1];
      bus.imm_addr = 10'(i * 7);
      bus.reg_addr = 10'(i * 13);
      bus.in_btn   = i[1];
      bus.in_data  = 32'hDEAD_0000 + i;
      bus.hlt      = i[3];
      bus.flag_in  = i[2];
      step();
      chk("halt_pc", 32'(bus.pc), 32'd9);
      chk("halt_st", 32'(bus.state), 32'd2);
    end
    chk("halt_value", bus.in_value, 32'd0);
    chk("halt_checkin", 32'(bus.checkin), 32'd0);
    idle();
    bus.in_btn = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("unhalt_pc", 32'(bus.pc), 32'd0);
    chk("unhalt_state", 32'(bus.state), 32'd0);
    step();
    chk("unhalt_run", 32'(bus.pc), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
